// File: rtl/enc_pkg.sv
// Shared types and the one-hot to binary encoding rule for the encoder slice.
package enc_pkg;

   localparam int unsigned WIDTH = 15;
   localparam int unsigned BW    = 4;
   localparam logic [BW-1:0] ZERO_CODE = '1;

   typedef struct packed {
      logic [BW-1:0] code;
      logic          err;
   } enc_entry_t;

   // Lowest set bit wins; any further set bit marks the vector illegal.
   // All-zero maps to ZERO_CODE so the block inverts the decoder exactly.
   function automatic enc_entry_t onehot_enc(input logic [WIDTH-1:0] vec);
      enc_entry_t r;
      logic       found;
      r.code = ZERO_CODE;
      r.err  = 1'b0;
      found  = 1'b0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         if (vec[k]) begin
            if (!found) begin
               r.code = k[BW-1:0];
               found  = 1'b1;
            end else begin
               r.err = 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// DEPTH-entry synchronous FIFO of encoder results with a registered head.
module enc_fifo
   import enc_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  enc_entry_t din,
   output enc_entry_t head,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   enc_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   always_comb begin
      do_push    = push && !full;
      do_pop     = pop && !empty;
      rd_next    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count_next = count + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Head is preloaded with the entry that will sit at rd_next, taking the
   // incoming word directly when it lands there; it holds once empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_next;
         count  <= count_next;
         if (count_next != '0)
            head <= (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
      end
   end

endmodule

// File: rtl/enc_onehot2bin_q.sv
// One-hot to binary re-encoder with illegal-vector flag, output FIFO and
// saturating error counter.
module enc_onehot2bin_q #(
   parameter int unsigned WIDTH = 15,
   parameter int unsigned BW    = 4,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_vec,
   output logic             in_ready,
   output logic             out_valid,
   output logic [BW-1:0]    out_code,
   output logic             out_err,
   input  logic             out_ready,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             err_clr
);

   enc_pkg::enc_entry_t enc;
   enc_pkg::enc_entry_t head;
   logic                full;
   logic                empty;
   logic                accept;
   logic                release_head;

   assign enc          = enc_pkg::onehot_enc(in_vec);
   assign in_ready     = !full;
   assign out_valid    = !empty;
   assign accept       = in_valid && in_ready;
   assign release_head = out_valid && out_ready;
   assign out_code     = head.code;
   assign out_err      = head.err;

   enc_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (accept),
      .pop  (release_head),
      .din  (enc),
      .head (head),
      .full (full),
      .empty(empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (accept && enc.err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_enc_onehot2bin_q.sv
// Directed, table-driven bench for enc_onehot2bin_q.
module tb_enc_onehot2bin_q;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [14:0] in_vec;
   logic        in_ready;
   logic        out_valid;
   logic [3:0]  out_code;
   logic        out_err;
   logic        out_ready;
   logic [7:0]  err_cnt;
   logic        err_clr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [14:0] vec;
      logic [3:0]  code;
      logic        err;
   } vec_t;

   vec_t tbl [9];

   always #5 clk = ~clk;

   enc_onehot2bin_q #(
      .WIDTH(15),
      .BW   (4),
      .DEPTH(2),
      .CNT_W(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_vec   (in_vec),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_code (out_code),
      .out_err  (out_err),
      .out_ready(out_ready),
      .err_cnt  (err_cnt),
      .err_clr  (err_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{15'h0001, 4'd0,  1'b0};
      tbl[1] = '{15'h0400, 4'd10, 1'b0};
      tbl[2] = '{15'h4000, 4'd14, 1'b0};
      tbl[3] = '{15'h0000, 4'd15, 1'b0};
      tbl[4] = '{15'h0006, 4'd1,  1'b1};
      tbl[5] = '{15'h4001, 4'd0,  1'b1};
      tbl[6] = '{15'h0100, 4'd8,  1'b0};
      tbl[7] = '{15'h7FFE, 4'd1,  1'b1};
      tbl[8] = '{15'h0002, 4'd1,  1'b0};

      rst = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; err_clr = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_err_cnt",   32'(err_cnt),   32'd0);
      check("rst_out_code",  32'(out_code),  32'd0);
      check("rst_out_err",   32'(out_err),   32'd0);
      #10 rst = 1'b1;
      step();

      // Table: one push per cycle, consumer always ready.
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_vec   = tbl[i].vec;
         check("tbl_in_ready", 32'(in_ready), 32'd1);
         step();
         check("tbl_out_valid", 32'(out_valid), 32'd1);
         check("tbl_code",      32'(out_code),  32'(tbl[i].code));
         check("tbl_err",       32'(out_err),   32'(tbl[i].err));
      end
      in_valid = 1'b0;
      step();
      check("drain_empty",     32'(out_valid), 32'd0);
      check("drain_hold_code", 32'(out_code),  32'd1);
      check("tbl_err_cnt",     32'(err_cnt),   32'd3);

      // Backpressure: second push fills, third is refused.
      out_ready = 1'b0;
      in_valid = 1'b1; in_vec = 15'h0002;
      step();
      check("bp_valid1", 32'(out_valid), 32'd1);
      check("bp_code1",  32'(out_code),  32'd1);
      check("bp_ready1", 32'(in_ready),  32'd1);
      in_vec = 15'h0008;
      step();
      check("bp_full",      32'(in_ready), 32'd0);
      check("bp_head_hold", 32'(out_code), 32'd1);
      in_vec = 15'h0010;
      for (int i = 0; i < 2; i++) begin
         step();
         check("bp_refuse_ready", 32'(in_ready), 32'd0);
         check("bp_refuse_code",  32'(out_code), 32'd1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check("bp_drain_valid", 32'(out_valid), 32'd1);
      check("bp_drain_code",  32'(out_code),  32'd3);
      check("bp_drain_ready", 32'(in_ready),  32'd1);
      step();
      check("bp_no_code4", 32'(out_valid), 32'd0);
      check("bp_hold3",    32'(out_code),  32'd3);
      check("bp_err_cnt",  32'(err_cnt),   32'd3);

      // Saturation of the error counter from 3.
      in_valid = 1'b1; in_vec = 15'h0003;
      for (int i = 0; i < 260; i++) begin
         step();
         if (i == 250) check("sat_254", 32'(err_cnt), 32'd254);
         if (i == 251) check("sat_255", 32'(err_cnt), 32'd255);
      end
      check("sat_hold", 32'(err_cnt), 32'd255);
      check("sat_code", 32'(out_code), 32'd0);
      check("sat_err",  32'(out_err),  32'd1);
      err_clr = 1'b1;
      step();
      check("clr_priority", 32'(err_cnt), 32'd0);
      err_clr = 1'b0;
      step();
      check("inc_after_clr", 32'(err_cnt), 32'd1);
      in_valid = 1'b0; err_clr = 1'b1;
      step();
      check("clr_alone", 32'(err_cnt), 32'd0);
      err_clr = 1'b0;
      step();

      // Streaming at occupancy 1 with a walking one-hot.
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_vec = 15'h0001 << (i % 15);
         step();
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_ready", 32'(in_ready),  32'd1);
         check("stream_code",  32'(out_code),  32'(i % 15));
      end
      in_valid = 1'b0;
      step();
      check("stream_done", 32'(out_valid), 32'd0);

      // Asynchronous reset with two entries held.
      out_ready = 1'b0; in_valid = 1'b1; in_vec = 15'h0030;
      step();
      in_vec = 15'h0040;
      step();
      check("pre_rst_full", 32'(in_ready), 32'd0);
      check("pre_rst_cnt",  32'(err_cnt),  32'd1);
      check("pre_rst_code", 32'(out_code), 32'd4);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_ready", 32'(in_ready),  32'd1);
      check("arst_cnt",   32'(err_cnt),   32'd0);
      check("arst_code",  32'(out_code),  32'd0);
      #9 rst = 1'b1;
      step();
      check("no_replay", 32'(out_valid), 32'd0);
      out_ready = 1'b1; in_valid = 1'b1; in_vec = 15'h0800;
      step();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_code",  32'(out_code),  32'd11);
      in_valid = 1'b0;
      step();
      check("post_rst_drain", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
